serial_word_comparator_msb_first_fsm: RTL

//   Serial magnitude comparator for words arriving most significant digit first,

---
 rtl/serial_word_comparator_msb_first_fsm.sv | 65 ++++++
 1 files changed

// File: rtl/serial_word_comparator_msb_first_fsm.sv
// serial_word_comparator_msb_first_fsm: MSB-first serial magnitude comparator with word framing and registered per-word result.
module serial_word_comparator_msb_first_fsm #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8,
  parameter bit SIGNED      = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               abort,
  output logic               word_active,
  output logic               res_valid,
  output logic               res_less,
  output logic               res_eq,
  output logic               res_greater
);
  typedef enum logic [1:0] {ST_EQUAL, ST_LESS, ST_GREATER} state_t;
  localparam int CW = WORD_DIGITS > 1 ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] MSB = DIGIT_W'(1) << (DIGIT_W - 1);
  state_t state, cur, dec;
  logic [CW-1:0] cnt;
  logic [DIGIT_W-1:0] a_c, b_c;
  logic first, last;
  always_comb begin
    first = cnt == '0;
    last  = cnt == LAST;
    // the sign digit is compared with its top bit inverted so negatives order below positives
    a_c   = a ^ ((SIGNED && first) ? MSB : '0);
    b_c   = b ^ ((SIGNED && first) ? MSB : '0);
    cur   = first ? ST_EQUAL : state;
    dec   = cur != ST_EQUAL ? cur : a_c < b_c ? ST_LESS : a_c > b_c ? ST_GREATER : ST_EQUAL;
  end
  assign word_active = cnt != '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EQUAL;
      cnt         <= '0;
      res_valid   <= 1'b0;
      res_less    <= 1'b0;
      res_eq      <= 1'b0;
      res_greater <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (abort) begin
        cnt   <= '0;
        state <= ST_EQUAL;
      end else if (in_valid) begin
        if (last) begin
          cnt         <= '0;
          state       <= ST_EQUAL;
          res_valid   <= 1'b1;
          res_less    <= dec == ST_LESS;
          res_eq      <= dec == ST_EQUAL;
          res_greater <= dec == ST_GREATER;
        end else begin
          cnt   <= cnt + 1'b1;
          state <= dec;
        end
      end
    end
  end
endmodule
